// File: rtl/signmag_pkg.sv
// Shared constants and result payload for the sign-magnitude to two's-complement converter.
//   DATA_W      : default sample width
//   ERRCNT_W    : width of the optional error counter
//   tc_result_t : converted sample with its flags {data, ovf, negzero}
package signmag_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ERRCNT_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ovf;
        logic              negzero;
    } tc_result_t;

endpackage

// File: rtl/sm2tc_core.sv
// Combinational sign-magnitude to two's-complement conversion with saturation.
// Ports:
//   sign    : input sign (1 = negative)
//   mag     : unsigned magnitude, N bits
//   data    : two's-complement result, saturated to the N-bit signed range
//   ovf     : magnitude did not fit and was clamped
//   negzero : input was sign=1, mag=0
module sm2tc_core
    import signmag_pkg::*;
#(
    parameter int unsigned N = DATA_W
) (
    input  logic         sign,
    input  logic [N-1:0] mag,
    output logic [N-1:0] data,
    output logic         ovf,
    output logic         negzero
);

    localparam logic [N-1:0] POS_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] NEG_MIN = {1'b1, {(N-1){1'b0}}};

    // mag_top alone (low bits zero) is exactly 2^(N-1), which is still
    // representable when negative.
    logic mag_top;
    logic mag_low_nz;

    assign mag_top    = mag[N-1];
    assign mag_low_nz = |mag[N-2:0];

    // Classify the magnitude against the signed range of the output.
    always_comb begin
        data    = mag;
        ovf     = 1'b0;
        negzero = 1'b0;
        if (!sign) begin
            if (mag_top) begin
                data = POS_MAX;
                ovf  = 1'b1;
            end
        end else if (!mag_top && !mag_low_nz) begin
            data    = '0;
            negzero = 1'b1;
        end else if (mag_top && mag_low_nz) begin
            data = NEG_MIN;
            ovf  = 1'b1;
        end else begin
            data = ~mag + N'(1);
        end
    end

endmodule

// File: rtl/signmag_to_tc16.sv
// Two-stage ready/valid pipeline converting sign-magnitude samples to
// saturated two's-complement.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : input sample present
//   in_ready    : input accepted this cycle (combinational)
//   in_sign     : input sign (1 = negative)
//   in_mag      : input magnitude, N bits
//   out_valid   : result present
//   out_ready   : downstream accepts result
//   out_data    : signed result, N bits
//   out_ovf     : result was saturated
//   out_negzero : input was negative zero
//   err_count   : saturating count of flagged output transfers
//                 (present only when SIGNMAG_ERRCNT_EN is defined)
module signmag_to_tc16
    import signmag_pkg::*;
#(
    parameter int unsigned N = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sign,
    input  logic [N-1:0] in_mag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ovf,
    output logic         out_negzero
`ifdef SIGNMAG_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    logic         s1_valid;
    logic         s1_sign;
    logic [N-1:0] s1_mag;

    logic [N-1:0] conv_data;
    logic         conv_ovf;
    logic         conv_negzero;

    logic in_fire;
    logic out_fire;
    logic s2_load;

    assign out_fire = out_valid & out_ready;
    // S2 can take a new sample when empty or being drained this edge.
    assign s2_load  = s1_valid & (~out_valid | out_ready);
    // S1 frees up whenever it is empty or can move forward into S2.
    assign in_ready = ~s1_valid | ~out_valid | out_ready;
    assign in_fire  = in_valid & in_ready;

    // Stage 1: raw input capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_sign  <= in_sign;
            s1_mag   <= in_mag;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    sm2tc_core #(
        .N (N)
    ) u_core (
        .sign    (s1_sign),
        .mag     (s1_mag),
        .data    (conv_data),
        .ovf     (conv_ovf),
        .negzero (conv_negzero)
    );

    // Stage 2: converted result; held while stalled by out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_ovf     <= 1'b0;
            out_negzero <= 1'b0;
        end else if (s2_load) begin
            out_valid   <= 1'b1;
            out_data    <= conv_data;
            out_ovf     <= conv_ovf;
            out_negzero <= conv_negzero;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SIGNMAG_ERRCNT_EN
    // Count flagged results as they leave; sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (out_fire && (out_ovf || out_negzero) && (err_count != {ERRCNT_W{1'b1}})) begin
            err_count <= err_count + ERRCNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_signmag_to_tc16.sv
module tb_signmag_to_tc16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [15:0] in_mag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        out_negzero;
`ifdef SIGNMAG_ERRCNT_EN
    logic [15:0] err_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    signmag_to_tc16 #(.N(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_mag      (in_mag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ovf     (out_ovf),
        .out_negzero (out_negzero)
`ifdef SIGNMAG_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed value of the sample, clamped to the 16-bit range.
    function automatic logic [17:0] model(input logic s, input logic [15:0] m);
        int   v;
        logic o;
        logic nz;
        v  = s ? -int'(m) : int'(m);
        nz = s && (m == 16'h0000);
        o  = 1'b0;
        if (v > 32767) begin
            v = 32767;
            o = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            o = 1'b1;
        end
        return {16'(v), o, nz};
    endfunction

    task automatic idle_drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_mag = '0; out_ready = 1'b0;
        #2;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_ovf !== 1'b0 || out_negzero !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b d=%h o=%b nz=%b rdy=%b, expected 0 0000 0 0 1",
                     out_valid, out_data, out_ovf, out_negzero, in_ready);
        end
`ifdef SIGNMAG_ERRCNT_EN
        vectors++;
        if (err_count !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_errcnt: got %h expected 0000", err_count);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_corners();
        logic        c_sign [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        logic [15:0] c_mag  [11] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF,
                                     16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'h8001, 16'hFFFF};
        logic [15:0] c_data [11] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                                     16'h0000, 16'hFFFF, 16'h8001, 16'h8000, 16'h8000, 16'h8000};
        logic        c_ovf  [11] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
        logic        c_nz   [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        int          err_exp = 0;
        for (int k = 0; k < 11; k++) begin
            in_valid = 1'b1; in_sign = c_sign[k]; in_mag = c_mag[k]; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== c_data[k] || out_ovf !== c_ovf[k] || out_negzero !== c_nz[k]) begin
                miscompares++;
                $display("FAIL corner_%0d: got v=%b d=%h o=%b nz=%b, expected 1 %h %b %b",
                         k, out_valid, out_data, out_ovf, out_negzero, c_data[k], c_ovf[k], c_nz[k]);
            end
            if (c_ovf[k] || c_nz[k]) err_exp++;
            @(negedge clk);
`ifdef SIGNMAG_ERRCNT_EN
            vectors++;
            if (err_count !== 16'(err_exp)) begin
                miscompares++;
                $display("FAIL corner_errcnt_%0d: got %h expected %h", k, err_count, 16'(err_exp));
            end
`endif
        end
    endtask

    task automatic test_sweep();
        int i;
        for (int t = 0; t < 65538; t++) begin
            i = t - 32768;
            in_valid  = (t < 65536);
            in_sign   = (i < 0);
            in_mag    = 16'((i < 0) ? -i : i);
            out_ready = 1'b1;
            #1;
            if (t >= 2) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== 16'(i - 2) || out_ovf !== 1'b0 || out_negzero !== 1'b0 || in_ready !== 1'b1) begin
                    miscompares++;
                    if (miscompares < 40)
                        $display("FAIL sweep_%0d: got v=%b d=%h o=%b nz=%b rdy=%b, expected 1 %h 0 0 1",
                                 i - 2, out_valid, out_data, out_ovf, out_negzero, in_ready, 16'(i - 2));
                end
            end else begin
                vectors++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL sweep_latency_%0d: got v=%b rdy=%b, expected 0 1", t, out_valid, in_ready);
                end
            end
            @(negedge clk);
        end
        idle_drain();
    endtask

    task automatic test_backpressure();
        logic [15:0] smp [3] = '{16'h0011, 16'h0022, 16'h8001};
        logic [15:0] exp_d [3] = '{16'h0011, 16'hFFDE, 16'h8000};
        logic        rdy_exp [5] = '{1, 1, 0, 0, 0};
        int          accepted = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_sign  = (accepted != 0);
            in_mag   = smp[accepted];
            #1;
            vectors++;
            if (in_ready !== rdy_exp[c]) begin
                miscompares++;
                $display("FAIL bp_ready_%0d: got %b expected %b", c, in_ready, rdy_exp[c]);
            end
            if (c >= 2) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== exp_d[0]) begin
                    miscompares++;
                    $display("FAIL bp_hold_%0d: got v=%b d=%h expected 1 %h", c, out_valid, out_data, exp_d[0]);
                end
            end
            if (in_valid && in_ready) accepted++;
            @(negedge clk);
        end
        // Release: third sample goes in as the first leaves.
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c == 0);
            #1;
            vectors++;
            if (c < 3) begin
                if (out_valid !== 1'b1 || out_data !== exp_d[c]) begin
                    miscompares++;
                    $display("FAIL bp_order_%0d: got v=%b d=%h expected 1 %h", c, out_valid, out_data, exp_d[c]);
                end
            end else if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_dup: got out_valid=%b expected 0", out_valid);
            end
            @(negedge clk);
        end
        idle_drain();
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b0;
        in_valid = 1'b1; in_sign = 1'b0; in_mag = 16'h1234;
        @(negedge clk);
        in_mag = 16'h4321;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_full_setup: got v=%b rdy=%b expected 1 0", out_valid, in_ready);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0) begin
            miscompares++;
            $display("FAIL rst_async: got v=%b rdy=%b d=%h expected 0 1 0000", out_valid, in_ready, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_stale_%0d: got out_valid=%b expected 0", c, out_valid);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [17:0] sb[$];
        logic [17:0] exp;
        logic [17:0] prev;
        logic        stalled = 1'b0;
        int          budget;
        logic        corner_pick [4];
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sign   = $urandom_range(0, 1);
            case ($urandom_range(0, 4))
                0:       in_mag = 16'h0000;
                1:       in_mag = 16'h8000;
                2:       in_mag = 16'h8001;
                3:       in_mag = 16'h7FFF;
                default: in_mag = 16'($urandom);
            endcase
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (stalled) begin
                vectors++;
                if (out_valid !== 1'b1 || {out_data, out_ovf, out_negzero} !== prev) begin
                    miscompares++;
                    $display("FAIL rnd_hold_%0d: got v=%b %h expected 1 %h", c, out_valid,
                             {out_data, out_ovf, out_negzero}, prev);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rnd_spurious_%0d: got %h expected no output", c, {out_data, out_ovf, out_negzero});
                end else begin
                    exp = sb.pop_front();
                    if ({out_data, out_ovf, out_negzero} !== exp) begin
                        miscompares++;
                        $display("FAIL rnd_data_%0d: got %h expected %h", c, {out_data, out_ovf, out_negzero}, exp);
                    end
                end
            end
            stalled = out_valid && !out_ready;
            prev    = {out_data, out_ovf, out_negzero};
            if (in_valid && in_ready) sb.push_back(model(in_sign, in_mag));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 50;
        while (sb.size() != 0 && budget > 0) begin
            #1;
            if (out_valid) begin
                exp = sb.pop_front();
                vectors++;
                if ({out_data, out_ovf, out_negzero} !== exp) begin
                    miscompares++;
                    $display("FAIL rnd_drain: got %h expected %h", {out_data, out_ovf, out_negzero}, exp);
                end
            end
            budget--;
            @(negedge clk);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rnd_timeout: got %0d samples outstanding expected 0", sb.size());
        end
        corner_pick[0] = 1'b0;
        idle_drain();
    endtask

`ifdef SIGNMAG_ERRCNT_EN
    task automatic test_err_saturation();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; in_sign = 1'b0; in_mag = 16'hFFFF; out_ready = 1'b1;
        repeat (65540) @(negedge clk);
        idle_drain();
        vectors++;
        if (err_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL err_sat: got %h expected FFFF", err_count);
        end
        in_valid = 1'b1; in_sign = 1'b1; in_mag = 16'h0000;
        repeat (5) @(negedge clk);
        idle_drain();
        vectors++;
        if (err_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL err_sat_hold: got %h expected FFFF", err_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_corners();
        test_sweep();
        test_backpressure();
        test_reset_inflight();
        test_random_stream();
`ifdef SIGNMAG_ERRCNT_EN
        test_err_saturation();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/signmag_to_tc16.md
SIGNMAG_TO_TC16 -- requirements
Module: signmag_to_tc16

Interface
REQ-001 Parameter: N, 16, data width in bits; SHALL support N >= 4.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: in_valid  input  1  input sample present.
REQ-005 Port: in_ready  output  1  block accepts input this cycle.
REQ-006 Port: in_sign  input  1  sign of input (1 = negative).
REQ-007 Port: in_mag  input  N  unsigned magnitude; 2^(N-1) is legal.
REQ-008 Port: out_valid  output  1  result present.
REQ-009 Port: out_ready  input  1  downstream accepts result.
REQ-010 Port: out_data  output  N  signed two's-complement result.
REQ-011 Port: out_ovf  output  1  result was saturated.
REQ-012 Port: out_negzero  output  1  input was negative zero.
REQ-013 Port: err_count  output  16  saturating error count; present only with SIGNMAG_ERRCNT_EN.

Function
REQ-014 A transfer SHALL occur on a side when valid and ready are both high at a rising edge.
REQ-015 The datapath SHALL be two register stages: S1 captures the input, S2 holds the converted result.
REQ-016 Latency SHALL be 2 cycles from input transfer to out_valid with out_ready held high; throughput SHALL be one sample per cycle.
REQ-017 S2 SHALL load from S1 when S1 is valid and S2 is empty or draining (out_valid & out_ready).
REQ-018 in_ready SHALL equal ~S1_valid | ~S2_valid | out_ready, computed combinationally.
REQ-019 Output registers SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 sign=0, mag <= 2^(N-1)-1: out_data = mag, flags 0.
REQ-021 sign=0, mag >= 2^(N-1): out_data = 2^(N-1)-1, out_ovf=1.
REQ-022 sign=1, 1 <= mag <= 2^(N-1): out_data = -mag (mag=2^(N-1) yields most negative value, ovf=0).
REQ-023 sign=1, mag > 2^(N-1): out_data = -2^(N-1), out_ovf=1.
REQ-024 sign=1, mag=0: out_data=0, out_negzero=1, out_ovf=0.
REQ-025 Flags SHALL travel with their sample and SHALL be valid only while out_valid=1.
REQ-026 Simultaneous input and output transfers with both stages full SHALL lose and duplicate no sample.
REQ-027 Input signals SHALL be ignored while in_ready=0.

Reset
REQ-028 rst high SHALL clear S1_valid, S2_valid and out_valid immediately; out_data, out_ovf and out_negzero SHALL reset to 0.
REQ-029 Samples in flight at reset SHALL be discarded; in_ready SHALL be 1 after reset.
REQ-030 err_count SHALL reset to 0.

Configuration
REQ-031 Macro SIGNMAG_ERRCNT_EN defined: err_count SHALL increment on each output transfer with out_ovf or out_negzero set, saturating at 16'hFFFF.
REQ-032 Macro undefined: the err_count port and its counter SHALL be absent, with no other behaviour change.

Structure
REQ-033 Package signmag_pkg SHALL hold the default width constant (16) and a result struct {data, ovf, negzero}.
REQ-034 Combinational conversion (REQ-020..024) SHALL live in sub-module sm2tc_core; signmag_to_tc16 holds the pipeline, handshake and counter.

Verification
REQ-035 Sweep: for every i in -32768..32767, drive sign=(i<0), mag=|i| with out_ready=1 -> out_data=i two cycles later, flags 0.
REQ-036 sign=0, mag=16'h8000 -> out_data=16'h7FFF, out_ovf=1; sign=1, mag=16'h8001 -> 16'h8000, out_ovf=1.
REQ-037 sign=1, mag=0 -> out_data=0, out_negzero=1; with macro defined, err_count increments by 1.
REQ-038 Backpressure: out_ready=0 for 5 cycles while feeding 3 samples -> in_ready drops after 2 accepted, output held, then order preserved on release.
REQ-039 Assert rst with both stages full -> out_valid=0 and in_ready=1 in the same cycle; no stale sample appears afterward.
REQ-040 Macro defined: force 65540 error transfers -> err_count=16'hFFFF and stays there.
